// File: rtl/sar_pkg.sv
// Shared types and constants for the 8-bit SAR interface blocks.
// The default latency and timeout are shared with the SAR controller.
package sar_pkg;

  localparam int SAR_WIDTH   = 8;
  localparam int ERR_W       = 8;
  localparam int DEF_CMP_LAT = 1;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sar_state_e;

endpackage

// File: rtl/sar_cmp_delay.sv
// DEPTH-deep 1-bit shift pipe modelling comparator settling latency.
// Clear has priority over shifting; both only act while en is high.
module sar_cmp_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] pipe_reg;
  logic [DEPTH-1:0] pipe_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = d;
      end else begin : g_body
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_reg <= '0;
    end else if (en) begin
      pipe_reg <= clr ? '0 : pipe_next;
    end
  end

  assign q = pipe_reg[DEPTH-1];

endmodule

// File: rtl/sar_cmp_responder.sv
// Digital stand-in for the SAR comparator and hold capacitor: answers trial
// codes, checks the final code on EOC, and counts mismatches and timeouts.
module sar_cmp_responder
  import sar_pkg::*;
#(
  parameter int CMP_LAT = DEF_CMP_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter bit CMP_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [SAR_WIDTH-1:0] sample_in,
  input  logic                 sample_req,
  input  logic [SAR_WIDTH-1:0] dac_code,
  input  logic                 sar_eoc,
  output logic                 cmp_out,
  output logic [SAR_WIDTH-1:0] held,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 result_match,
  output logic                 timeout,
  output logic [ERR_W-1:0]     err_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  sar_state_e           state_reg, state_next;
  logic [SAR_WIDTH-1:0] held_reg, held_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [ERR_W-1:0]     err_reg, err_next;
  logic                 valid_reg, valid_next;
  logic                 match_reg, match_next;
  logic                 timeout_reg, timeout_next;
  logic                 pipe_clr;
  logic                 pipe_en;
  logic                 raw_cmp;

  assign raw_cmp = CMP_POL ? (held_reg >= dac_code) : (held_reg < dac_code);

  // The pipe only advances during HOLD, so IDLE keeps showing the last decision.
  assign pipe_en = ena && ((state_reg == HOLD) || pipe_clr);

  sar_cmp_delay #(
    .DEPTH(CMP_LAT)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pipe_en),
    .clr  (pipe_clr),
    .d    (raw_cmp),
    .q    (cmp_out)
  );

  always_comb begin
    state_next   = state_reg;
    held_next    = held_reg;
    timer_next   = timer_reg;
    err_next     = err_reg;
    valid_next   = 1'b0;
    match_next   = match_reg;
    timeout_next = 1'b0;
    pipe_clr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sample_req) begin
          held_next  = sample_in;
          timer_next = '0;
          pipe_clr   = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        timer_next = timer_reg + 1'b1;
        if (sar_eoc) begin
          valid_next = 1'b1;
          match_next = (dac_code == held_reg);
          if ((dac_code != held_reg) && (err_reg != ERR_MAX)) err_next = err_reg + 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT != 0) && (timer_reg == TIMER_LAST)) begin
          timeout_next = 1'b1;
          if (err_reg != ERR_MAX) err_next = err_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      held_reg    <= '0;
      timer_reg   <= '0;
      err_reg     <= '0;
      valid_reg   <= 1'b0;
      match_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      held_reg    <= held_next;
      timer_reg   <= timer_next;
      err_reg     <= err_next;
      valid_reg   <= valid_next;
      match_reg   <= match_next;
      timeout_reg <= timeout_next;
    end else begin
      // Frozen: a pulse already shown must not be stretched over the stall.
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end
  end

  assign held         = held_reg;
  assign busy         = (state_reg == HOLD);
  assign result_valid = valid_reg;
  assign result_match = match_reg;
  assign timeout      = timeout_reg;
  assign err_count    = err_reg;

endmodule
